// File: rtl/line_window_buffer_pkg.sv
// Shared types and helpers for the line window buffer.
//   lb_state_e  : frame-tracking FSM states
//   safe_clog2  : address/counter width that never collapses to zero bits
package linebuffer_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    STREAM   = 2'd2
  } lb_state_e;

  function automatic int safe_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/line_window_buffer_line_ram.sv
// line_ram: one-read one-write synchronous RAM used as a single line store.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data : write port
//   rd_en   : read strobe,  rd_addr         : read address
//   rd_data : registered read data, updated only when rd_en is high
// A read and a write to the same address in one cycle returns the old word.
// No reset on storage or read register so the array maps onto block RAM.
module line_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  localparam int AW        = linebuffer_pkg::safe_clog2(DEPTH)
) (
  input  bit                    clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: streaming multi-line buffer producing one vertical
// column of NUM_LINES pixels per accepted raster pixel.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid      : in_pixel / in_sof valid this cycle
//   in_sof        : first pixel of a frame
//   in_pixel      : raster-order pixel
//   out_valid     : one cycle after each accepted pixel
//   out_col       : slice k = pixel (x, y-k), slice 0 in the LSBs
//   out_x, out_y  : position of slice 0
//   out_win_valid : every slice belongs to the current frame
//   out_eol       : last column of a line
//   out_eof       : last pixel of the frame
//   frame_err     : one-cycle pulse on a missing or early start-of-frame
module line_window_buffer
  import linebuffer_pkg::*;
#(
  parameter int PIXEL_DEPTH = 8,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int NUM_LINES   = 3,
  localparam int XW         = safe_clog2(WIDTH),
  localparam int YW         = safe_clog2(HEIGHT)
) (
  input  bit                                clk,
  input  bit                                rst_n,
  input  logic                              in_valid,
  input  logic                              in_sof,
  input  logic [PIXEL_DEPTH-1:0]            in_pixel,
  output logic                              out_valid,
  output logic [NUM_LINES*PIXEL_DEPTH-1:0]  out_col,
  output logic [XW-1:0]                     out_x,
  output logic [YW-1:0]                     out_y,
  output logic                              out_win_valid,
  output logic                              out_eol,
  output logic                              out_eof,
  output logic                              frame_err
);

  localparam int NR                 = NUM_LINES - 1;
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_WIN   = YW'(NUM_LINES - 1);

  lb_state_e               state_reg, state_next;
  logic [XW-1:0]           x_reg, x_next, cur_x;
  logic [YW-1:0]           y_reg, y_next, cur_y;
  logic                    accept, err_next, last_col, last_pix;

  logic                    out_valid_reg, out_win_reg, out_eol_reg, out_eof_reg, frame_err_reg;
  logic [XW-1:0]           out_x_reg;
  logic [YW-1:0]           out_y_reg;
  logic [PIXEL_DEPTH-1:0]  pix_reg;

  // Cascade writes into line k>0 are issued one cycle after the accept,
  // once the registered read of line k-1 is available.
  logic                    pend_valid_reg;
  logic [XW-1:0]           pend_addr_reg;
  logic                    fwd_reg;

  always_comb begin
    accept   = 1'b0;
    err_next = 1'b0;
    cur_x    = x_reg;
    cur_y    = y_reg;
    if (in_valid) begin
      if (state_reg == WAIT_SOF) begin
        if (in_sof) begin
          accept = 1'b1;
          cur_x  = '0;
          cur_y  = '0;
        end else begin
          err_next = 1'b1;
        end
      end else begin
        accept = 1'b1;
        if (in_sof) begin
          // Early start-of-frame restarts the raster at (0,0).
          err_next = 1'b1;
          cur_x    = '0;
          cur_y    = '0;
        end
      end
    end
    last_col = (cur_x == X_LAST);
    last_pix = last_col && (cur_y == Y_LAST);
    x_next   = last_col ? '0 : cur_x + 1'b1;
    y_next   = cur_y;
    if (last_col) y_next = last_pix ? '0 : cur_y + 1'b1;
    if (last_pix)             state_next = WAIT_SOF;
    else if (y_next >= Y_WIN) state_next = STREAM;
    else                      state_next = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= WAIT_SOF;
      x_reg          <= '0;
      y_reg          <= '0;
      out_valid_reg  <= 1'b0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      out_win_reg    <= 1'b0;
      out_eol_reg    <= 1'b0;
      out_eof_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      pix_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      fwd_reg        <= 1'b0;
    end else begin
      out_valid_reg  <= accept;
      frame_err_reg  <= err_next;
      pend_valid_reg <= accept;
      if (accept) begin
        state_reg     <= state_next;
        x_reg         <= x_next;
        y_reg         <= y_next;
        out_x_reg     <= cur_x;
        out_y_reg     <= cur_y;
        out_win_reg   <= (cur_y >= Y_WIN);
        out_eol_reg   <= last_col;
        out_eof_reg   <= last_pix;
        pix_reg       <= in_pixel;
        pend_addr_reg <= cur_x;
        // A cascade write landing on the address being read this cycle
        // would be missed by the read-before-write RAM; remember to bypass.
        fwd_reg       <= pend_valid_reg && (pend_addr_reg == cur_x);
      end
    end
  end

  // Logical contents of line k at the last accepted address.
  logic [PIXEL_DEPTH-1:0] ram_rd [NR];
  logic [PIXEL_DEPTH-1:0] ram_q  [NR];

  generate
    for (genvar gi = 0; gi < NR; gi++) begin : g_line
      logic                   wr_en;
      logic [XW-1:0]          wr_addr;
      logic [PIXEL_DEPTH-1:0] wr_data;

      if (gi == 0) begin : g_head
        assign wr_en     = accept;
        assign wr_addr   = cur_x;
        assign wr_data   = in_pixel;
        assign ram_q[gi] = ram_rd[gi];
      end else begin : g_tail
        logic [PIXEL_DEPTH-1:0] fwd_data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      fwd_data_reg <= '0;
          else if (accept) fwd_data_reg <= ram_q[gi-1];
        end

        assign wr_en     = pend_valid_reg;
        assign wr_addr   = pend_addr_reg;
        assign wr_data   = ram_q[gi-1];
        assign ram_q[gi] = fwd_reg ? fwd_data_reg : ram_rd[gi];
      end

      line_ram #(
        .DATA_WIDTH (PIXEL_DEPTH),
        .DEPTH      (WIDTH)
      ) u_line_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (cur_x),
        .rd_data (ram_rd[gi])
      );

      // RAM read registers have no reset; gate so outputs read 0 when idle.
      assign out_col[(gi+1)*PIXEL_DEPTH +: PIXEL_DEPTH] = out_valid_reg ? ram_q[gi] : '0;
    end
  endgenerate

  assign out_col[PIXEL_DEPTH-1:0] = pix_reg;
  assign out_valid     = out_valid_reg;
  assign out_x         = out_x_reg;
  assign out_y         = out_y_reg;
  assign out_win_valid = out_win_reg;
  assign out_eol       = out_eol_reg;
  assign out_eof       = out_eof_reg;
  assign frame_err     = frame_err_reg;

endmodule
